mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- MEM pipeline stage. Consumes the EX/MEM bundle: ALU result, store data, MEM/WB control fields, destination register.
- Performs word loads and stores against an internal data memory with a configurable number of wait states.
- Asserts StallOut upstream while an access is in progress.
- Drives the MEM/WB pipeline register consumed by write-back.

Parameters:
ADDR_WIDTH, 8, number of word-address bits; memory depth 2**ADDR_WIDTH words of 32 bits.
MEM_LATENCY, 2, wait cycles per memory access; legal range 0..7.

Ports:
Clk  input  1  clock; all state updates on the rising edge.
Rst_n  input  1  synchronous active-low reset.
ValidIn  input  1  EX/MEM bundle valid; 0 marks a bubble.
ResultIn  input  32  ALU result; used as the byte address for memory ops.
DataIn  input  32  store data.
MEMControlIn  input  2  bit0 MemRead, bit1 MemWrite.
WBControlIn  input  2  bit0 RegWrite, bit1 MemToReg; forwarded to WB.
RdIn  input  5  destination register.
StallOut  output  1  combinational; upstream holds all inputs stable while high.
ValidOut  output  1  MEM/WB valid.
ReadDataOut  output  32  load data.
ALUResultOut  output  32  ResultIn passed through.
WBControlOut  output  2  MEM/WB control.
RdOut  output  5  destination register passed through.
MisalignOut  output  1  one-cycle flag accompanying a suppressed misaligned access.

Behaviour:
Definitions
- Word index = ResultIn[ADDR_WIDTH+1:2]. Upper address bits are ignored, so addresses wrap modulo memory depth.
- A cycle carries a memory op when ValidIn=1 and MEMControlIn != 00.

Reset
- Rst_n=0 at a rising edge forces state IDLE, wait counter 0, and all registered outputs 0: ValidOut, ReadDataOut, ALUResultOut, WBControlOut, RdOut, MisalignOut.
- StallOut is 0 while reset is asserted.
- Memory contents are not reset.
- Reset during ACCESS aborts the op; a pending store is discarded and does not write.

FSM states: IDLE, ACCESS.
- IDLE, no memory op presented:
  - At the edge, MEM/WB regs load ValidOut=ValidIn, ALUResultOut=ResultIn, RdOut=RdIn, ReadDataOut=0.
  - WBControlOut=WBControlIn if ValidIn, else 00.
  - Latency 1 cycle. StallOut=0.
- IDLE, memory op with ResultIn[1:0] != 00 (misaligned):
  - No memory access, no stall.
  - MEM/WB loads ValidOut=1, ALUResultOut, RdOut, WBControlOut=00 (write-back suppressed), ReadDataOut=0, MisalignOut=1 for one cycle.
- IDLE, aligned memory op, MEM_LATENCY=0:
  - Completes at the same edge.
  - Store writes mem[index]=DataIn.
  - Load sets ReadDataOut=mem[index], using the pre-edge contents.
- IDLE, aligned memory op, MEM_LATENCY=L>0:
  - StallOut=1 combinationally in that cycle (T).
  - At the edge, latch address, data and control; set counter=L-1 and go to ACCESS.
  - MEM/WB loads a bubble: ValidOut=0, WBControlOut=00.
- ACCESS:
  - StallOut=1 while counter != 0; each edge decrements the counter and loads a bubble into MEM/WB.
  - When counter==0, StallOut=0 (cycle T+L) and the op completes at that edge using the latched copy:
    - store writes memory;
    - load sets ReadDataOut=mem[index];
    - ValidOut=1; WBControlOut, ALUResultOut and RdOut are taken from the latched copy.
  - Next state is IDLE.
  - Net: op presented at cycle T produces MEM/WB valid after the edge ending cycle T+L, with exactly L stall cycles.
- Back-to-back ops:
  - Inputs present in cycle T+L are the same held op; the upstream advances only on that edge.
  - The next op is evaluated in IDLE at cycle T+L+1.
- MEMControlIn=11 (read and write): treated as a store. Memory is written, ReadDataOut=0, and the op takes the normal latency.
- Store followed by load to the same address: the load returns the newly stored value.
- WBControlOut is always 00 whenever ValidOut=0.

Test Plan:
- Reset: hold Rst_n=0 for 2 cycles with ValidIn=1 → all outputs 0, StallOut=0; release → next ALU op (ResultIn=0x0000_0010, Rd=5, WB=01) appears after 1 edge with ValidOut=1, RdOut=5.
- Store/load, L=2: store DataIn=0xDEADBEEF at 0x0000_0040 → StallOut high exactly 2 cycles, then ValidOut=1; subsequent load from 0x40 with WB=11 → ReadDataOut=0xDEADBEEF after the edge ending its 3rd cycle.
- Misaligned: load from 0x0000_0042 → no stall, MisalignOut=1 one cycle, WBControlOut=00, memory unchanged.
- Wrap: with ADDR_WIDTH=8, store 0x1234 at 0x0000_0400, load from 0x0 → 0x1234.
- Reset mid-access: store 0xCAFEF00D to 0x80 (L=2), assert Rst_n=0 in the 2nd stall cycle → outputs 0, StallOut=0; later load from 0x80 returns the prior value.
- L=0 build: alternating store/load each cycle to 0x10/0x14 → StallOut never asserts; one valid MEM/WB result per cycle with correct data.

Source files
------------

// File: rtl/mem_stage.sv
// MEM pipeline stage: word loads/stores against an internal data memory with
// a fixed number of wait states, stalling upstream and feeding the MEM/WB register.
module mem_stage #(
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned MEM_LATENCY = 2
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        ValidIn,
  input  logic [31:0] ResultIn,
  input  logic [31:0] DataIn,
  input  logic [1:0]  MEMControlIn,
  input  logic [1:0]  WBControlIn,
  input  logic [4:0]  RdIn,
  output logic        StallOut,
  output logic        ValidOut,
  output logic [31:0] ReadDataOut,
  output logic [31:0] ALUResultOut,
  output logic [1:0]  WBControlOut,
  output logic [4:0]  RdOut,
  output logic        MisalignOut
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam int unsigned CNT_W = 3;
  localparam logic [CNT_W-1:0] LOAD_CNT = CNT_W'((MEM_LATENCY > 0) ? (MEM_LATENCY - 1) : 0);
  localparam logic HAS_WAIT = (MEM_LATENCY > 0);

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  state_t              state;
  logic [CNT_W-1:0]    waitCnt;

  // Copy of the op captured when a multi-cycle access starts
  logic [31:0]         latResult;
  logic [31:0]         latData;
  logic [1:0]          latMem;
  logic [1:0]          latWb;
  logic [4:0]          latRd;

  logic [31:0]         mem [DEPTH];

  logic                memOp;
  logic                misaligned;
  logic                startWait;
  logic                doneNow;
  logic [31:0]         curResult;
  logic [31:0]         curData;
  logic [1:0]          curMem;
  logic [1:0]          curWb;
  logic [4:0]          curRd;
  logic [ADDR_WIDTH-1:0] curIdx;
  logic                memWrite;
  logic [31:0]         loadData;

  // Select the op being worked on: live inputs in IDLE, the latched copy in ACCESS
  always_comb begin
    memOp      = ValidIn && (MEMControlIn != 2'b00);
    misaligned = memOp && (ResultIn[1:0] != 2'b00);
    startWait  = 1'b0;
    doneNow    = 1'b0;
    curResult  = ResultIn;
    curData    = DataIn;
    curMem     = MEMControlIn;
    curWb      = WBControlIn;
    curRd      = RdIn;
    if (state == ACCESS) begin
      curResult = latResult;
      curData   = latData;
      curMem    = latMem;
      curWb     = latWb;
      curRd     = latRd;
      doneNow   = (waitCnt == '0);
    end else if (memOp && !misaligned) begin
      if (HAS_WAIT) begin
        startWait = 1'b1;
      end else begin
        doneNow = 1'b1;
      end
    end
  end

  // Read-and-write ops behave as stores, so only a pure read returns data
  always_comb begin
    curIdx   = curResult[ADDR_WIDTH+1:2];
    memWrite = Rst_n && doneNow && curMem[1];
    loadData = (curMem == 2'b01) ? mem[curIdx] : 32'h0;
    StallOut = Rst_n && (startWait || ((state == ACCESS) && (waitCnt != '0)));
  end

  // Data memory; contents survive reset
  always_ff @(posedge Clk) begin
    if (memWrite) begin
      mem[curIdx] <= curData;
    end
  end

  // Stage FSM and MEM/WB register
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state        <= IDLE;
      waitCnt      <= '0;
      latResult    <= '0;
      latData      <= '0;
      latMem       <= '0;
      latWb        <= '0;
      latRd        <= '0;
      ValidOut     <= 1'b0;
      ReadDataOut  <= '0;
      ALUResultOut <= '0;
      WBControlOut <= '0;
      RdOut        <= '0;
      MisalignOut  <= 1'b0;
    end else begin
      MisalignOut <= 1'b0;
      case (state)
        IDLE: begin
          if (startWait) begin
            latResult    <= ResultIn;
            latData      <= DataIn;
            latMem       <= MEMControlIn;
            latWb        <= WBControlIn;
            latRd        <= RdIn;
            waitCnt      <= LOAD_CNT;
            state        <= ACCESS;
            ValidOut     <= 1'b0;
            WBControlOut <= '0;
          end else if (misaligned) begin
            ValidOut     <= 1'b1;
            ALUResultOut <= ResultIn;
            RdOut        <= RdIn;
            WBControlOut <= '0;
            ReadDataOut  <= '0;
            MisalignOut  <= 1'b1;
          end else if (doneNow) begin
            ValidOut     <= 1'b1;
            ALUResultOut <= curResult;
            RdOut        <= curRd;
            WBControlOut <= curWb;
            ReadDataOut  <= loadData;
          end else begin
            ValidOut     <= ValidIn;
            ALUResultOut <= ResultIn;
            RdOut        <= RdIn;
            ReadDataOut  <= '0;
            WBControlOut <= ValidIn ? WBControlIn : 2'b00;
          end
        end
        ACCESS: begin
          if (waitCnt != '0) begin
            waitCnt      <= waitCnt - CNT_W'(1);
            ValidOut     <= 1'b0;
            WBControlOut <= '0;
          end else begin
            ValidOut     <= 1'b1;
            ALUResultOut <= curResult;
            RdOut        <= curRd;
            WBControlOut <= curWb;
            ReadDataOut  <= loadData;
            state        <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: one instance with two wait states, one with none.
module tb_mem_stage;

  localparam int unsigned NDUT = 2;

  typedef struct {
    int          d;
    logic [31:0] res;
    logic [31:0] rdata;
    logic [4:0]  rd;
    logic [1:0]  wb;
    logic        mis;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rstN;
  logic        validIn  [NDUT];
  logic [31:0] resultIn [NDUT];
  logic [31:0] dataIn   [NDUT];
  logic [1:0]  memCtl   [NDUT];
  logic [1:0]  wbCtl    [NDUT];
  logic [4:0]  rdIn     [NDUT];
  logic        stall    [NDUT];
  logic        validOut [NDUT];
  logic [31:0] readData [NDUT];
  logic [31:0] aluRes   [NDUT];
  logic [1:0]  wbOut    [NDUT];
  logic [4:0]  rdOut    [NDUT];
  logic        misOut   [NDUT];

  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  exp_t expQ[$];
  logic [31:0] model [NDUT][256];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NDUT; g++) begin : gDut
    mem_stage #(.ADDR_WIDTH(8), .MEM_LATENCY(g == 0 ? 2 : 0)) uDut (
      .Clk(clk), .Rst_n(rstN), .ValidIn(validIn[g]), .ResultIn(resultIn[g]),
      .DataIn(dataIn[g]), .MEMControlIn(memCtl[g]), .WBControlIn(wbCtl[g]),
      .RdIn(rdIn[g]), .StallOut(stall[g]), .ValidOut(validOut[g]),
      .ReadDataOut(readData[g]), .ALUResultOut(aluRes[g]),
      .WBControlOut(wbOut[g]), .RdOut(rdOut[g]), .MisalignOut(misOut[g])
    );
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int lat(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  // Monitor: pops the scoreboard whenever an instance presents a valid MEM/WB entry
  for (genvar g = 0; g < NDUT; g++) begin : gMon
    always @(negedge clk) begin : mon
      exp_t e;
      if (rstN === 1'b1) begin
        if (validOut[g]) begin
          if (expQ.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_valid: dut%0d got result %h expected no output", g, aluRes[g]);
          end else begin
            e = expQ.pop_front();
            check("dut_id", 32'(g), 32'(e.d));
            check("alu_result", aluRes[g], e.res);
            check("rd", 32'(rdOut[g]), 32'(e.rd));
            check("wb_ctrl", 32'(wbOut[g]), 32'(e.wb));
            check("read_data", readData[g], e.rdata);
            check("misalign", 32'(misOut[g]), 32'(e.mis));
            check("latency_cycle", 32'(cyc), 32'(e.cyc));
          end
        end else begin
          check("bubble_wb", 32'(wbOut[g]), 32'h0);
        end
      end
    end
  end

  task automatic idleAll();
    for (int d = 0; d < NDUT; d++) begin
      validIn[d] = 1'b0;
      memCtl[d]  = 2'b00;
    end
  endtask

  // Present one op, predict its result from the memory model, and count stall cycles
  task automatic issue(input int d, input logic v, input logic [31:0] res, input logic [31:0] data,
                       input logic [1:0] mc, input logic [1:0] wb, input logic [4:0] rd);
    exp_t e;
    int   expStall;
    int   stalls;
    logic [7:0] idx;
    validIn[d]  = v;
    resultIn[d] = res;
    dataIn[d]   = data;
    memCtl[d]   = mc;
    wbCtl[d]    = wb;
    rdIn[d]     = rd;
    idx      = 8'((res >> 2) % 256);
    expStall = 0;
    e.d = d; e.res = res; e.rd = rd; e.wb = wb; e.rdata = 32'h0; e.mis = 1'b0;
    if (v && (mc != 2'b00)) begin
      if ((res % 4) != 0) begin
        e.wb  = 2'b00;
        e.mis = 1'b1;
      end else begin
        expStall = lat(d);
        if (mc[1]) model[d][idx] = data;
        else e.rdata = model[d][idx];
      end
    end
    e.cyc = cyc + expStall + 1;
    if (v) expQ.push_back(e);
    stalls = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!stall[d]) break;
      stalls++;
      @(posedge clk); #1;
    end
    check("stall_cycles", 32'(stalls), 32'(expStall));
    @(posedge clk); #1;
  endtask

  task automatic drain();
    for (int k = 0; k < 50 && expQ.size() != 0; k++) @(posedge clk);
    #1;
    if (expQ.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: %0d results outstanding expected 0", expQ.size());
      expQ.delete();
    end
  endtask

  task automatic randomOps(input int d, input int n);
    int          kind;
    logic [31:0] res;
    logic [1:0]  mc;
    for (int i = 0; i < n; i++) begin
      kind = int'($urandom_range(0, 9));
      res  = $urandom() & 32'hFFFF_FFFC;
      case (kind)
        0: issue(d, 1'b0, $urandom(), $urandom(), 2'($urandom()), 2'($urandom()), 5'($urandom()));
        1, 2: issue(d, 1'b1, $urandom(), $urandom(), 2'b00, 2'($urandom()), 5'($urandom()));
        3, 4, 9: issue(d, 1'b1, res, $urandom(), 2'b01, 2'($urandom()), 5'($urandom()));
        5, 6: issue(d, 1'b1, res, $urandom(), 2'b10, 2'($urandom()), 5'($urandom()));
        7: issue(d, 1'b1, res, $urandom(), 2'b11, 2'($urandom()), 5'($urandom()));
        default: begin
          mc = 2'($urandom_range(1, 3));
          issue(d, 1'b1, res | 32'($urandom_range(1, 3)), $urandom(), mc, 2'($urandom()), 5'($urandom()));
        end
      endcase
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rstN = 1'b0;
    for (int d = 0; d < NDUT; d++) begin
      validIn[d] = 1'b1; resultIn[d] = 32'h0000_0055; dataIn[d] = 32'h1111_2222;
      memCtl[d]  = 2'b01; wbCtl[d] = 2'b11; rdIn[d] = 5'd7;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      check("reset_valid", 32'(validOut[d]), 32'h0);
      check("reset_rdata", readData[d], 32'h0);
      check("reset_alu", aluRes[d], 32'h0);
      check("reset_wb", 32'(wbOut[d]), 32'h0);
      check("reset_rd", 32'(rdOut[d]), 32'h0);
      check("reset_mis", 32'(misOut[d]), 32'h0);
      check("reset_stall", 32'(stall[d]), 32'h0);
    end
    @(posedge clk); #1;
    rstN = 1'b1;
    idleAll();
    issue(0, 1'b1, 32'h0000_0010, 32'h0, 2'b00, 2'b01, 5'd5);

    // Give every word a known value before loads are checked
    for (int i = 0; i < 256; i++) issue(0, 1'b1, 32'(i * 4), $urandom(), 2'b10, 2'b00, 5'd0);
    issue(0, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 2'b10, 2'b00, 5'd1);
    issue(0, 1'b1, 32'h0000_0040, 32'h0, 2'b01, 2'b11, 5'd9);
    issue(0, 1'b1, 32'h0000_0042, 32'h0, 2'b01, 2'b11, 5'd9);
    issue(0, 1'b1, 32'h0000_0041, 32'h5555_AAAA, 2'b10, 2'b01, 5'd2);
    issue(0, 1'b1, 32'h0000_0040, 32'h0, 2'b01, 2'b11, 5'd3);
    issue(0, 1'b1, 32'h0000_0400, 32'h0000_1234, 2'b10, 2'b00, 5'd4);
    issue(0, 1'b1, 32'h0000_0000, 32'h0, 2'b01, 2'b11, 5'd4);
    issue(0, 1'b1, 32'h0000_0044, 32'h7777_8888, 2'b11, 2'b11, 5'd6);
    issue(0, 1'b1, 32'h0000_0044, 32'h0, 2'b01, 2'b11, 5'd6);
    drain();

    // Abort a store with reset in its second stall cycle
    validIn[0] = 1'b1; resultIn[0] = 32'h0000_0080; dataIn[0] = 32'hCAFE_F00D;
    memCtl[0] = 2'b10; wbCtl[0] = 2'b00; rdIn[0] = 5'd3;
    @(posedge clk); #1;
    rstN = 1'b0;
    @(negedge clk);
    check("midreset_stall_low", 32'(stall[0]), 32'h0);
    @(posedge clk);
    @(negedge clk);
    check("midreset_valid", 32'(validOut[0]), 32'h0);
    check("midreset_alu", aluRes[0], 32'h0);
    check("midreset_wb", 32'(wbOut[0]), 32'h0);
    check("midreset_stall", 32'(stall[0]), 32'h0);
    @(posedge clk); #1;
    idleAll();
    rstN = 1'b1;
    issue(0, 1'b1, 32'h0000_0080, 32'h0, 2'b01, 2'b11, 5'd8);
    randomOps(0, 300);
    issue(0, 1'b0, 32'h0, 32'h0, 2'b00, 2'b00, 5'd0);
    drain();

    // Zero-wait-state instance
    for (int i = 0; i < 256; i++) issue(1, 1'b1, 32'(i * 4), $urandom(), 2'b10, 2'($urandom()), 5'd0);
    for (int i = 0; i < 24; i++) begin
      case (i % 4)
        0: issue(1, 1'b1, 32'h0000_0010, $urandom(), 2'b10, 2'b00, 5'd10);
        1: issue(1, 1'b1, 32'h0000_0010, 32'h0, 2'b01, 2'b11, 5'd11);
        2: issue(1, 1'b1, 32'h0000_0014, $urandom(), 2'b10, 2'b00, 5'd12);
        default: issue(1, 1'b1, 32'h0000_0014, 32'h0, 2'b01, 2'b11, 5'd13);
      endcase
    end
    randomOps(1, 200);
    issue(1, 1'b0, 32'h0, 32'h0, 2'b00, 2'b00, 5'd0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
